fft_bfly2_pipe: RTL

//   Parametrised fixed-point radix-2 DIT butterfly with twiddle multiply: x0 = a + b*W, x1 = a - b*W.

---
 rtl/fft_bfly2_if.sv | 44 ++++
 rtl/fft_bfly2_pipe.sv | 148 ++++++++++++++
 2 files changed

// File: rtl/fft_bfly2_if.sv
// Handshake bundle for the radix-2 butterfly: input sample side,
// output sample side and the sticky overflow flag.
interface fft_bfly2_if #(
  parameter int DW   = 16,
  parameter int TW   = 16,
  parameter int TAGW = 8
);
  logic                   in_valid;
  logic                   in_ready;
  logic signed [DW-1:0]   a_re;
  logic signed [DW-1:0]   a_img;
  logic signed [DW-1:0]   b_re;
  logic signed [DW-1:0]   b_img;
  logic signed [TW-1:0]   w_re;
  logic signed [TW-1:0]   w_img;
  logic                   inv;
  logic                   scale_en;
  logic [TAGW-1:0]        in_tag;
  logic                   out_valid;
  logic                   out_ready;
  logic signed [DW-1:0]   x0_re;
  logic signed [DW-1:0]   x0_img;
  logic signed [DW-1:0]   x1_re;
  logic signed [DW-1:0]   x1_img;
  logic [TAGW-1:0]        out_tag;
  logic                   ovf;
  logic                   ovf_clr;

  modport master (
    output in_valid, a_re, a_img, b_re, b_img,
    output w_re, w_img, inv, scale_en, in_tag,
    output out_ready, ovf_clr,
    input  in_ready, out_valid, out_tag, ovf,
    input  x0_re, x0_img, x1_re, x1_img
  );

  modport slave (
    input  in_valid, a_re, a_img, b_re, b_img,
    input  w_re, w_img, inv, scale_en, in_tag,
    input  out_ready, ovf_clr,
    output in_ready, out_valid, out_tag, ovf,
    output x0_re, x0_img, x1_re, x1_img
  );
endinterface

// File: rtl/fft_bfly2_pipe.sv
// Pipelined radix-2 DIT butterfly x0 = a + b*W, x1 = a - b*W
// with optional conj(W), /2 scaling, saturation and sticky ovf.
module fft_bfly2_pipe #(
  parameter int DW   = 16,
  parameter int TW   = 16,
  parameter int TAGW = 8
) (
  input logic        clk,
  input logic        rst_n,
  fft_bfly2_if.slave bus
);
  localparam int PW = DW + TW;
  localparam int SW = DW + 3;

  localparam logic signed [TW-1:0] WMIN = {1'b1, {(TW-1){1'b0}}};
  localparam logic signed [TW-1:0] WMAX = {1'b0, {(TW-1){1'b1}}};
  localparam logic signed [PW:0] RND =
    {{(PW-TW+2){1'b0}}, 1'b1, {(TW-2){1'b0}}};
  localparam logic signed [SW-1:0] ONE = {{(SW-1){1'b0}}, 1'b1};
  localparam logic signed [SW-1:0] SMAX = {4'b0000, {(DW-1){1'b1}}};
  localparam logic signed [SW-1:0] SMIN = {4'b1111, {(DW-1){1'b0}}};

  function automatic logic signed [PW-1:0] mul(
    input logic signed [DW-1:0] b,
    input logic signed [TW-1:0] w
  );
    return $signed({{TW{b[DW-1]}}, b}) * $signed({{DW{w[TW-1]}}, w});
  endfunction

  function automatic logic signed [SW-1:0] bfly(
    input logic signed [DW-1:0] a,
    input logic signed [DW+1:0] t,
    input logic                 sub,
    input logic                 sc
  );
    logic signed [SW-1:0] ax, tx, s;
    ax = $signed({{3{a[DW-1]}}, a});
    tx = $signed({t[DW+1], t});
    s  = sub ? ax - tx : ax + tx;
    if (sc) s = (s + ONE) >>> 1;
    return s;
  endfunction

  function automatic logic signed [DW-1:0] sat(
    input logic signed [SW-1:0] s
  );
    if (s > SMAX) return {1'b0, {(DW-1){1'b1}}};
    if (s < SMIN) return {1'b1, {(DW-1){1'b0}}};
    return s[DW-1:0];
  endfunction

  function automatic logic clip(input logic signed [SW-1:0] s);
    return (s > SMAX) || (s < SMIN);
  endfunction

  logic en;
  assign en = ~bus.out_valid | bus.out_ready;
  assign bus.in_ready = en;

  logic                 v1, v2, v3;
  logic                 sc1, sc2, sc3;
  logic [TAGW-1:0]      tag1, tag2, tag3;
  logic signed [DW-1:0] a1r, a1i, a2r, a2i, a3r, a3i;
  logic signed [DW-1:0] b1r, b1i;
  logic signed [TW-1:0] w1r, w1i, wi_c;
  logic signed [PW-1:0] p_rr, p_ii, p_ri, p_ir;
  logic signed [DW+1:0] t3r, t3i;
  logic signed [PW:0]   tr_s, ti_s;
  logic signed [SW-1:0] s0r, s0i, s1r, s1i;
  logic                 any_clip;
  logic                 unused_lsb;

  // -(-1.0) is not representable in Q1.(TW-1); clamp to +max
  always_comb begin
    wi_c = bus.w_img;
    if (bus.inv) wi_c = (bus.w_img == WMIN) ? WMAX : -bus.w_img;
  end

  always_comb begin
    tr_s = $signed({p_rr[PW-1], p_rr}) - $signed({p_ii[PW-1], p_ii}) + RND;
    ti_s = $signed({p_ri[PW-1], p_ri}) + $signed({p_ir[PW-1], p_ir}) + RND;
  end

  assign unused_lsb = ^{tr_s[TW-2:0], ti_s[TW-2:0]};

  always_comb begin
    s0r = bfly(a3r, t3r, 1'b0, sc3);
    s0i = bfly(a3i, t3i, 1'b0, sc3);
    s1r = bfly(a3r, t3r, 1'b1, sc3);
    s1i = bfly(a3i, t3i, 1'b1, sc3);
    any_clip = clip(s0r) | clip(s0i) | clip(s1r) | clip(s1i);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v1 <= 1'b0;  v2 <= 1'b0;  v3 <= 1'b0;
      sc1 <= 1'b0; sc2 <= 1'b0; sc3 <= 1'b0;
      tag1 <= '0;  tag2 <= '0;  tag3 <= '0;
      a1r <= '0;   a1i <= '0;   a2r <= '0;
      a2i <= '0;   a3r <= '0;   a3i <= '0;
      b1r <= '0;   b1i <= '0;   w1r <= '0;   w1i <= '0;
      p_rr <= '0;  p_ii <= '0;  p_ri <= '0;  p_ir <= '0;
      t3r <= '0;   t3i <= '0;
      bus.out_valid <= 1'b0;
      bus.out_tag   <= '0;
      bus.x0_re <= '0; bus.x0_img <= '0;
      bus.x1_re <= '0; bus.x1_img <= '0;
    end else if (en) begin
      v1   <= bus.in_valid;
      a1r  <= bus.a_re;
      a1i  <= bus.a_img;
      b1r  <= bus.b_re;
      b1i  <= bus.b_img;
      w1r  <= bus.w_re;
      w1i  <= wi_c;
      sc1  <= bus.scale_en;
      tag1 <= bus.in_tag;
      v2   <= v1;
      a2r  <= a1r;
      a2i  <= a1i;
      sc2  <= sc1;
      tag2 <= tag1;
      p_rr <= mul(b1r, w1r);
      p_ii <= mul(b1i, w1i);
      p_ri <= mul(b1r, w1i);
      p_ir <= mul(b1i, w1r);
      v3   <= v2;
      a3r  <= a2r;
      a3i  <= a2i;
      sc3  <= sc2;
      tag3 <= tag2;
      t3r  <= tr_s[PW:TW-1];
      t3i  <= ti_s[PW:TW-1];
      bus.out_valid <= v3;
      bus.out_tag   <= tag3;
      bus.x0_re  <= sat(s0r);
      bus.x0_img <= sat(s0i);
      bus.x1_re  <= sat(s1r);
      bus.x1_img <= sat(s1i);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)            bus.ovf <= 1'b0;
    else if (bus.ovf_clr)  bus.ovf <= 1'b0;
    else if (en && v3 && any_clip) bus.ovf <= 1'b1;
  end
endmodule
